digit_scan_ctrl: RTL and testbench
==================================

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal range 2..8).
REQ-002 Parameter PRESCALE, default 16, clock cycles per scan phase (legal range >=1).
REQ-003 Parameter SCROLL_FRAMES, default 64, frames per scroll step (legal range >=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  scan enable; 0 freezes the scan.
REQ-007 load_valid  input  1  new display word offered.
REQ-008 load_data  input  4*NUM_DIGITS  one nibble per digit; digit d = bits [4d+3:4d].
REQ-009 scroll  input  1  scroll mode request.
REQ-010 load_ready  output  1  block can accept a display word.
REQ-011 an  output  NUM_DIGITS  active-low digit enables.
REQ-012 char  output  4  nibble for the 7-segment decoder.
REQ-013 frame_done  output  1  one-cycle pulse at end of each frame.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 while enable=1 and produce a tick on the cycle it equals PRESCALE-1, then wrap to 0.
REQ-015 On each tick, the 2-bit phase SHALL increment; when phase wraps 3->0, digit index SHALL increment, wrapping NUM_DIGITS-1 -> 0.
REQ-016 frame_done SHALL be 1 for exactly the cycle after the tick on which digit wraps to 0 and phase wraps to 0; frame length = 4*NUM_DIGITS*PRESCALE cycles.
REQ-017 an and char SHALL be registered: one-cycle latency from the state change.
REQ-018 an[d] SHALL be 0 only while enable=1, digit index=d and phase=2; all other bits are 1 (phases 0,1,3 are blanking guards).
REQ-019 char SHALL equal shadow nibble (digit+offset) mod NUM_DIGITS, constant across all four phases of a slot.
REQ-020 enable=0 SHALL hold prescaler, phase, digit and offset, and force an to all ones on the next cycle; re-enabling resumes from the held state.
REQ-021 load_ready=1 when the pending buffer is empty; load_valid&load_ready captures load_data into pending and drops load_ready on the next cycle.
REQ-022 load_valid while load_ready=0 SHALL be ignored; data is not captured.
REQ-023 On the frame-end tick, a pending word held before that cycle SHALL move to the shadow register; load_ready rises the cycle after; a word accepted on the same cycle stays pending until the next frame end.
REQ-024 Shadow update SHALL only occur at frame end, never mid-frame (no tearing).

Reset
REQ-025 reset=0 SHALL immediately clear prescaler, phase, digit, offset, pending and shadow to 0.
REQ-026 During and after reset: an=all ones, char=0, frame_done=0, load_ready=1.
REQ-027 Reset mid-frame or mid-handshake SHALL discard pending data; no partial transfer.

Configuration
REQ-028 Macro DIGIT_SCAN_SCROLL_EN compiles in scrolling.
REQ-029 With DIGIT_SCAN_SCROLL_EN: while scroll=1, offset increments (mod NUM_DIGITS) every SCROLL_FRAMES frames at frame end; offset resets to 0 on every shadow update and when scroll=0.
REQ-030 Without DIGIT_SCAN_SCROLL_EN: offset is constant 0, scroll is ignored, no frame-count logic is synthesised.

Verification (NUM_DIGITS=4, PRESCALE=2, SCROLL_FRAMES=2)
REQ-031 Reset asserted mid-frame -> same cycle an=4'b1111, char=0, load_ready=1, frame_done=0; shadow reads 0.
REQ-032 Load 16'h1234 at cycle 3 -> shadow unchanged until frame end (cycle 32 tick); next frame slot 0 shows an=4'b1110, char=4 for 2 cycles, slot 3 an=4'b0111, char=1.
REQ-033 load_valid held high with 16'hAAAA then 16'h5555 -> only 16'hAAAA accepted; load_ready=0 until cycle after frame_done, then 16'h5555 accepted.
REQ-034 enable=0 during slot 1 phase 2 -> an=4'b1111 next cycle, counters frozen 10 cycles; enable=1 resumes slot 1 phase 2 with remaining prescale count.
REQ-035 DIGIT_SCAN_SCROLL_EN defined, scroll=1, shadow 16'h1234 -> after 2 frames slot 0 char=3, after 8 frames char=4 again; new load resets to char=4.
REQ-036 frame_done checked as one-cycle pulse every 32 cycles over 10 frames with enable=1.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_ctrl
// Purpose  : Multiplexed 7-segment digit scanner with a double-buffered
//            display word. Optional macro DIGIT_SCAN_SCROLL_EN adds scrolling.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
   parameter int NUM_DIGITS    = 4,
   parameter int PRESCALE      = 16,
   parameter int SCROLL_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic                    scroll,
   output logic                    load_ready,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [3:0]              char,
   output logic                    frame_done
);

   localparam int c_dig_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int c_presc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_presc_w-1:0] c_presc_max  = c_presc_w'(PRESCALE - 1);
   localparam logic [c_dig_w-1:0]   c_digit_max  = c_dig_w'(NUM_DIGITS - 1);
   localparam logic [c_dig_w:0]     c_num_digits = (c_dig_w + 1)'(NUM_DIGITS);

   logic [c_presc_w-1:0]    r_presc;
   logic [1:0]              r_phase;
   logic [c_dig_w-1:0]      r_digit;
   logic                    r_pend_valid;
   logic [4*NUM_DIGITS-1:0] r_pend_data;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [3:0]              r_char;
   logic                    r_frame_done;

   logic                    w_tick;
   logic                    w_phase_wrap;
   logic                    w_frame_end;
   logic                    w_shadow_upd;
   logic [c_dig_w-1:0]      w_offset;
   logic [c_dig_w:0]        w_idx_sum;
   logic [c_dig_w:0]        w_idx;
   logic [NUM_DIGITS-1:0]   w_an;
   logic [3:0]              w_char;

   assign w_tick       = enable && (r_presc == c_presc_max);
   assign w_phase_wrap = w_tick && (r_phase == 2'd3);
   assign w_frame_end  = w_phase_wrap && (r_digit == c_digit_max);
   // Only a word that was already pending before the frame-end cycle transfers
   assign w_shadow_upd = w_frame_end && r_pend_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc      <= '0;
         r_phase      <= 2'd0;
         r_digit      <= '0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_shadow     <= '0;
         r_an         <= '1;
         r_char       <= 4'd0;
         r_frame_done <= 1'b0;
      end else begin
         if (enable) begin
            r_presc <= w_tick ? '0 : r_presc + c_presc_w'(1);
         end
         if (w_tick) begin
            r_phase <= r_phase + 2'd1;
         end
         if (w_phase_wrap) begin
            r_digit <= (r_digit == c_digit_max) ? '0 : r_digit + c_dig_w'(1);
         end
         r_frame_done <= w_frame_end;
         if (w_shadow_upd) begin
            r_shadow     <= r_pend_data;
            r_pend_valid <= 1'b0;
         end else if (load_valid && !r_pend_valid) begin
            r_pend_data  <= load_data;
            r_pend_valid <= 1'b1;
         end
         r_an   <= w_an;
         r_char <= w_char;
      end
   end

   always_comb begin
      w_idx_sum = {1'b0, r_digit} + {1'b0, w_offset};
      w_idx     = (w_idx_sum >= c_num_digits) ? (w_idx_sum - c_num_digits) : w_idx_sum;
      w_char    = 4'd0;
      w_an      = '1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (w_idx == (c_dig_w + 1)'(d)) begin
            w_char = r_shadow[4*d +: 4];
         end
         // Phases 0, 1 and 3 keep the digit dark as ghosting guards
         if (enable && (r_phase == 2'd2) && (r_digit == c_dig_w'(d))) begin
            w_an[d] = 1'b0;
         end
      end
   end

`ifdef DIGIT_SCAN_SCROLL_EN
   localparam int c_fc_w = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
   localparam logic [c_fc_w-1:0] c_fc_max = c_fc_w'(SCROLL_FRAMES - 1);

   logic [c_fc_w-1:0]  r_frame_cnt;
   logic [c_dig_w-1:0] r_offset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame_cnt <= '0;
         r_offset    <= '0;
      end else if (w_shadow_upd || !scroll) begin
         r_frame_cnt <= '0;
         r_offset    <= '0;
      end else if (w_frame_end) begin
         if (r_frame_cnt == c_fc_max) begin
            r_frame_cnt <= '0;
            r_offset    <= (r_offset == c_digit_max) ? '0 : r_offset + c_dig_w'(1);
         end else begin
            r_frame_cnt <= r_frame_cnt + c_fc_w'(1);
         end
      end
   end

   assign w_offset = r_offset;
`else
   logic w_unused_scroll;

   assign w_unused_scroll = scroll;
   assign w_offset        = '0;
`endif

   assign load_ready = !r_pend_valid;
   assign an         = r_an;
   assign char       = r_char;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_ctrl
// Purpose  : Directed self-checking bench for digit_scan_ctrl (4 digits,
//            prescale 2, scroll every 2 frames).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_digit_scan_ctrl;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        load_valid;
   logic [15:0] load_data;
   logic        scroll;
   logic        load_ready;
   logic [3:0]  an;
   logic [3:0]  char;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   digit_scan_ctrl #(
      .NUM_DIGITS    (4),
      .PRESCALE      (2),
      .SCROLL_FRAMES (2)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load_valid (load_valid),
      .load_data  (load_data),
      .scroll     (scroll),
      .load_ready (load_ready),
      .an         (an),
      .char       (char),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns the number of negedges until frame_done is seen (bounded)
   task automatic wait_fd(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (frame_done !== 1'b1 && cycles < budget);
      check("fd_seen", frame_done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_scroll [4];
      exp_scroll = '{3, 2, 1, 4};
      reset = 1'b0; enable = 1'b0; load_valid = 1'b0; load_data = 16'h0; scroll = 1'b0;
      step(3);
      check("rst_an",    an,         4'hF);
      check("rst_char",  char,       4'h0);
      check("rst_fd",    frame_done, 1'b0);
      check("rst_ready", load_ready, 1'b1);

      // Load 0x1234 three cycles after reset release
      reset = 1'b1; enable = 1'b1;
      step(3);
      load_valid = 1'b1; load_data = 16'h1234;
      step(1);
      load_valid = 1'b0;
      check("ready_drop",     load_ready, 1'b0);
      check("char_pre_frame", char,       4'h0);
      wait_fd(40, cyc);
      check("first_frame_len", cyc, 28);
      check("ready_after_fe", load_ready, 1'b1);
      check("char_fe_old",    char,       4'h0);
      step(5);
      check("s0p2_an",   an,   4'hE);
      check("s0p2_char", char, 4'h4);
      step(1);
      check("s0p2b_an",   an,   4'hE);
      check("s0p2b_char", char, 4'h4);
      step(7);
      check("s1p2_an",   an,   4'hD);
      check("s1p2_char", char, 4'h3);
      step(16);
      check("s3p2_an",   an,   4'h7);
      check("s3p2_char", char, 4'h1);
      step(1);
      check("s3p2b_an",   an,   4'h7);
      check("s3p2b_char", char, 4'h1);
      wait_fd(40, cyc);
      check("frame_len", cyc, 2);

      // Back-to-back offers: second word must wait for the next frame end
      load_valid = 1'b1; load_data = 16'hAAAA;
      step(1);
      check("busy_ready", load_ready, 1'b0);
      load_data = 16'h5555;
      wait_fd(40, cyc);
      check("busy_frame_len", cyc, 31);
      check("busy_ready_fe", load_ready, 1'b1);
      check("busy_char_fe",  char,       4'h1);
      step(1);
      load_valid = 1'b0;
      check("second_accept", load_ready, 1'b0);
      check("char_aaaa",     char,       4'hA);
      wait_fd(40, cyc);
      step(1);
      check("char_5555",  char,       4'h5);
      check("ready_5555", load_ready, 1'b1);

      // Freeze during slot 1 phase 2
      step(12);
      check("pre_freeze_an", an, 4'hD);
      enable = 1'b0;
      step(1);
      check("freeze_an", an, 4'hF);
      step(9);
      check("freeze_an_hold", an,         4'hF);
      check("freeze_fd",      frame_done, 1'b0);
      enable = 1'b1;
      step(1);
      check("resume_an", an, 4'hD);
      step(1);
      check("resume_p3_an", an, 4'hF);
      wait_fd(40, cyc);
      check("resume_remaining", cyc, 17);

      for (int f = 0; f < 10; f++) begin
         wait_fd(40, cyc);
         check("fd_period", cyc, 32);
      end

      // Scroll over shadow 0x1234
      load_valid = 1'b1; load_data = 16'h1234;
      step(1);
      load_valid = 1'b0;
      wait_fd(40, cyc);
      scroll = 1'b1;
      step(1);
      check("scroll_f0", char, 4'h4);
`ifdef DIGIT_SCAN_SCROLL_EN
      for (int k = 0; k < 4; k++) begin
         wait_fd(40, cyc);
         wait_fd(40, cyc);
         step(1);
         check("scroll_step", char, exp_scroll[k]);
      end
      wait_fd(40, cyc);
      wait_fd(40, cyc);
      step(1);
      check("scroll_f10", char, 4'h3);
      load_valid = 1'b1; load_data = 16'h1234;
      step(1);
      load_valid = 1'b0;
      wait_fd(40, cyc);
      step(1);
      check("scroll_reload", char, 4'h4);
`else
      wait_fd(40, cyc);
      wait_fd(40, cyc);
      step(1);
      check("noscroll", char, 4'h4);
      check("noscroll_ref", exp_scroll[3], char);
`endif
      scroll = 1'b0;

      // Reset mid-frame with a pending word
      load_valid = 1'b1; load_data = 16'hBEEF;
      step(1);
      load_valid = 1'b0;
      step(5);
      check("pend_before_rst", load_ready, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("async_rst_an",    an,         4'hF);
      check("async_rst_char",  char,       4'h0);
      check("async_rst_fd",    frame_done, 1'b0);
      check("async_rst_ready", load_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      wait_fd(40, cyc);
      check("post_rst_frame_len", cyc, 32);
      step(1);
      check("rst_discard_char", char, 4'h0);
      step(4);
      check("post_rst_an",   an,   4'hE);
      check("post_rst_char", char, 4'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
